// File: rtl/uart_rx_frame_pkg.sv
// rtl/uart_rx_frame_pkg.sv - shared UART receive types, frame constants and parity helper
package uart_rx_frame_pkg;

  localparam int UART_OVERSAMPLE = 8;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  // data_xor is the reduction XOR of the data bits; odd selects odd parity
  function automatic logic parity_mismatch(input logic data_xor, input logic par_bit, input logic odd);
    return (data_xor ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-byte valid/ready port with frame and parity status
interface uart_rx_frame_if
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_parity_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_frame_sync.sv
// rtl/uart_rx_frame_sync.sv - rx_serial synchroniser, line falling-edge and oversample tick detect
module uart_rx_frame_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_baud_clk,
  input  logic rx_serial,
  output logic rxd,
  output logic fall,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_q;
  logic                   baud_q;

  // Line flops reset high so a reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      rxd_q  <= 1'b1;
      baud_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
      rxd_q  <= sync_q[SYNC_STAGES-1];
      baud_q <= rx_baud_clk;
    end
  end

  assign rxd  = sync_q[SYNC_STAGES-1];
  assign fall = rxd_q & ~rxd;
  assign tick = rx_baud_clk & ~baud_q;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer: start detect, mid-bit sampling, parity/stop check, output register
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_baud_clk,
  input  logic            rx_serial,
  input  logic            parity_en,
  input  logic            parity_odd,
  uart_rx_frame_if.master rx_if,
  output logic            rx_overrun,
  input  logic            overrun_clr,
  output logic            rx_busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxd;
  logic fall;
  logic tick;

  uart_rx_state_e       state_q, state_n;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_n;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_en_q, par_en_n;
  logic                 par_odd_q, par_odd_n;
  logic                 par_err_q, par_err_n;
  logic                 deliver;
  logic                 drop;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic                 overrun_q;

  uart_rx_frame_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset       (reset),
    .rx_baud_clk (rx_baud_clk),
    .rx_serial   (rx_serial),
    .rxd         (rxd),
    .fall        (fall),
    .tick        (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      tick_cnt_q <= tick_cnt_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      par_en_q   <= par_en_n;
      par_odd_q  <= par_odd_n;
      par_err_q  <= par_err_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    tick_cnt_n = tick_cnt_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    par_en_n   = par_en_q;
    par_odd_n  = par_odd_q;
    par_err_n  = par_err_q;
    deliver    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end

      // Half a bit after the edge: a high line means the start was a glitch
      START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_MID) begin
            if (rxd) begin
              state_n = IDLE;
            end else begin
              state_n    = DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
              par_en_n   = parity_en;
              par_odd_n  = parity_odd;
              par_err_n  = 1'b0;
            end
          end else begin
            tick_cnt_n = tick_cnt_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            shift_n    = {rxd, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_n = par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_n = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_n = tick_cnt_q + TW'(1);
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            par_err_n  = parity_mismatch(^shift_q, rxd, par_odd_q);
            state_n    = STOP;
          end else begin
            tick_cnt_n = tick_cnt_q + TW'(1);
          end
        end
      end

      // Return to IDLE mid stop bit so the next start edge is never missed
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            deliver    = 1'b1;
            state_n    = IDLE;
          end else begin
            tick_cnt_n = tick_cnt_q + TW'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign drop = deliver & valid_q & ~rx_if.rx_ready;

  // A frame only overwrites the held byte if that byte leaves this same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (deliver && !drop) begin
        data_q  <= shift_q;
        ferr_q  <= ~rxd;
        perr_q  <= par_en_q & par_err_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_parity_err = perr_q;
  assign rx_overrun          = overrun_q;
  assign rx_busy             = (state_q != IDLE);

endmodule
